// File: rtl/vga_rx_pkg.sv
// Shared lock-FSM state, default 640x480 geometry and CRC constants for the VGA sink decoder.
// Pure declarations and a helper function: no latency or backpressure of its own.
package vga_rx_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int H_START = DEF_H_SYNC + DEF_H_BACK;
  localparam int V_START = DEF_V_SYNC + DEF_V_BACK;

  // Counters park here out of reset so the first sync edge is not judged.
  localparam logic [9:0] POS_MAX = 10'h3FF;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One byte of CRC-16-CCITT, data MSB first, no reflection.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_rx_crc16.sv
// Running CRC-16-CCITT over 24-bit pixels, three bytes (MSB first) folded per enabled clk.
// Result visible 1 clk after the enable; init wins over en; no backpressure.
module vga_rx_crc16
  import vga_rx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [23:0] data,
  output logic [15:0] crc
);

  logic [15:0] crc_nxt;

  always_comb begin
    crc_nxt = crc16_byte(crc, data[23:16]);
    crc_nxt = crc16_byte(crc_nxt, data[15:8]);
    crc_nxt = crc16_byte(crc_nxt, data[7:0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= CRC_INIT;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc_nxt;
    end
  end

endmodule

// File: rtl/vga_rx_decoder.sv
// VGA sink: syncs, counts, checks timing and locks; pixels out 1 clk after the processing strobe (syncs/RGB lag pins 2 strobes).
// No backpressure: all state holds between vga_clk strobes. Optional frame CRC under VGA_RX_CRC_EN.
module vga_rx_decoder
  import vga_rx_pkg::*;
#(
  parameter int H_VISIBLE       = DEF_H_VISIBLE,
  parameter int H_FRONT         = DEF_H_FRONT,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BACK          = DEF_H_BACK,
  parameter int V_VISIBLE       = DEF_V_VISIBLE,
  parameter int V_FRONT         = DEF_V_FRONT,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BACK          = DEF_V_BACK,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_clk,
  input  logic        hor_sync,
  input  logic        ver_sync,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic        pixel_valid,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [23:0] pixel_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err,
  output logic [15:0] frame_crc,
  output logic        frame_crc_valid
);

  localparam int         LINE_LEN    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int         FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST      = 10'(LINE_LEN - 1);
  localparam logic [9:0] V_LAST      = 10'(FRAME_LINES - 1);
  localparam logic [9:0] X_FIRST     = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] X_LAST      = 10'(H_SYNC + H_BACK + H_VISIBLE - 1);
  localparam logic [9:0] Y_FIRST     = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] Y_LAST      = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);
  localparam logic       SYNC_IDLE   = SYNC_ACTIVE_LOW;

  logic [1:0]  hs_pipe, vs_pipe;
  logic        hs_prev, vs_prev;
  logic [23:0] rgb_d1, rgb_d2;
  logic        hs_act, vs_act, hs_edge, vs_edge;
  logic [9:0]  h_pos, v_pos, h_nxt, v_nxt;
  logic        h_err, v_err, err_seen;
  logic        in_window, pix_hit, tim_err_nxt;
  lock_state_t state, state_nxt;

  // Pin levels re-timed on strobes only; RGB rides the same two stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_pipe <= {2{SYNC_IDLE}};
      vs_pipe <= {2{SYNC_IDLE}};
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      rgb_d1  <= '0;
      rgb_d2  <= '0;
    end else if (vga_clk) begin
      hs_pipe <= {hs_pipe[0], hor_sync};
      vs_pipe <= {vs_pipe[0], ver_sync};
      hs_prev <= hs_act;
      vs_prev <= vs_act;
      rgb_d1  <= {red, green, blue};
      rgb_d2  <= rgb_d1;
    end
  end

  assign hs_act  = hs_pipe[1] ^ SYNC_ACTIVE_LOW;
  assign vs_act  = vs_pipe[1] ^ SYNC_ACTIVE_LOW;
  assign hs_edge = vga_clk & hs_act & ~hs_prev;
  assign vs_edge = vga_clk & vs_act & ~vs_prev;

  // A saturated counter means "no reference yet", so it never raises an error.
  assign h_err = hs_edge && (h_pos != H_LAST) && (h_pos != POS_MAX);
  assign v_err = vs_edge && (v_pos != V_LAST) && (v_pos != POS_MAX);

  always_comb begin
    h_nxt = h_pos;
    v_nxt = v_pos;
    if (vga_clk) begin
      if (hs_edge) begin
        h_nxt = '0;
      end else if (h_pos != POS_MAX) begin
        h_nxt = h_pos + 10'd1;
      end
      if (vs_edge) begin
        v_nxt = '0;
      end else if (hs_edge && (v_pos != POS_MAX)) begin
        v_nxt = v_pos + 10'd1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    tim_err_nxt = 1'b0;
    case (state)
      ST_UNLOCKED: begin
        if (vs_edge) state_nxt = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (vs_edge && !(err_seen || h_err || v_err)) state_nxt = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (h_err || v_err) begin
          state_nxt   = ST_UNLOCKED;
          tim_err_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_UNLOCKED;
    endcase
  end

  // err_seen covers the frame in progress; each vsync edge starts a fresh record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_UNLOCKED;
      h_pos    <= POS_MAX;
      v_pos    <= POS_MAX;
      err_seen <= 1'b0;
    end else begin
      state <= state_nxt;
      h_pos <= h_nxt;
      v_pos <= v_nxt;
      if (vs_edge) begin
        err_seen <= 1'b0;
      end else if (h_err || v_err) begin
        err_seen <= 1'b1;
      end
    end
  end

  assign in_window = (h_nxt >= X_FIRST) && (h_nxt <= X_LAST) &&
                     (v_nxt >= Y_FIRST) && (v_nxt <= Y_LAST);
  assign pix_hit   = vga_clk && (state_nxt == ST_LOCKED) && in_window;
  assign locked    = (state == ST_LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_rgb   <= '0;
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      pixel_valid <= pix_hit;
      frame_start <= vs_edge;
      timing_err  <= tim_err_nxt;
      if (pix_hit) begin
        pixel_x   <= h_nxt - X_FIRST;
        pixel_y   <= v_nxt - Y_FIRST;
        pixel_rgb <= rgb_d2;
      end
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc_run;
  logic        crc_frame_ok;

  vga_rx_crc16 u_crc (
    .clk   (clk),
    .reset (reset),
    .init  (vs_edge),
    .en    (pix_hit),
    .data  (rgb_d2),
    .crc   (crc_run)
  );

  // Only a frame that started and ended in LOCKED gets its CRC reported.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_crc       <= '0;
      frame_crc_valid <= 1'b0;
      crc_frame_ok    <= 1'b0;
    end else begin
      frame_crc_valid <= 1'b0;
      if (vs_edge) begin
        if (crc_frame_ok && (state_nxt == ST_LOCKED)) begin
          frame_crc       <= crc_run;
          frame_crc_valid <= 1'b1;
        end
        crc_frame_ok <= (state_nxt == ST_LOCKED);
      end else if (state_nxt != ST_LOCKED) begin
        crc_frame_ok <= 1'b0;
      end
    end
  end
`else
  assign frame_crc       = '0;
  assign frame_crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Bench for vga_rx_decoder on a scaled-down raster; a scoreboard queue holds the pixels expected while locked.
`timescale 1ns/1ps
module tb_vga_rx_decoder;

  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int XF = HS + HB;
  localparam int YF = VS + VB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vga_clk = 1'b0;
  logic        hor_sync = 1'b1;
  logic        ver_sync = 1'b1;
  logic [7:0]  red = '0, green = '0, blue = '0;
  logic        pixel_valid, frame_start, locked, timing_err, frame_crc_valid;
  logic [9:0]  pixel_x, pixel_y;
  logic [23:0] pixel_rgb;
  logic [15:0] frame_crc;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] crc_q[$];
  int n_cmp = 0, n_bad = 0;
  int pv_cnt = 0, fs_cnt = 0, te_cnt = 0;
  int xmin = 1023, xmax = 0, ymin = 1023, ymax = 0;
  bit seen_origin = 1'b0, seen_corner = 1'b0;

  always #5 clk = ~clk;

  vga_rx_decoder #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .vga_clk(vga_clk),
    .hor_sync(hor_sync), .ver_sync(ver_sync),
    .red(red), .green(green), .blue(blue),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_rgb(pixel_rgb),
    .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
    .frame_crc(frame_crc), .frame_crc_valid(frame_crc_valid)
  );

  // Output monitor: pops the scoreboard on every pixel_valid and counts pulses.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      if (pixel_valid) begin
        pv_cnt++;
        if (pixel_x < xmin) xmin = pixel_x;
        if (pixel_x > xmax) xmax = pixel_x;
        if (pixel_y < ymin) ymin = pixel_y;
        if (pixel_y > ymax) ymax = pixel_y;
        if (pixel_x == 0 && pixel_y == 0) seen_origin = 1'b1;
        if (pixel_x == HV - 1 && pixel_y == VV - 1) seen_corner = 1'b1;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pixel: got x=%0d y=%0d rgb=%h, required no pixel_valid",
                   pixel_x, pixel_y, pixel_rgb);
        end else begin
          e = exp_q.pop_front();
          if ({pixel_x, pixel_y, pixel_rgb} !== {e.x, e.y, e.rgb}) begin
            n_bad++;
            $display("FAIL pixel: got x=%0d y=%0d rgb=%h, required x=%0d y=%0d rgb=%h",
                     pixel_x, pixel_y, pixel_rgb, e.x, e.y, e.rgb);
          end
        end
      end
      if (frame_start) fs_cnt++;
      if (timing_err) te_cnt++;
      if (frame_crc_valid) crc_q.push_back(frame_crc);
    end
  end

  function automatic logic [23:0] pix_colour(input int x, input int y, input int mode);
    logic [7:0] xb, yb;
    xb = 8'(x);
    yb = 8'(y);
    if (mode == 0) return {xb, yb, 8'hA5};
    if (mode == 2 && x == 3 && y == 2) return 24'h000100;
    return 24'h000000;
  endfunction

  task automatic strobe(input logic hs_on, input logic vs_on, input logic [23:0] rgb);
    hor_sync = ~hs_on;
    ver_sync = ~vs_on;
    {red, green, blue} = rgb;
    vga_clk = 1'b1;
    @(negedge clk);
    vga_clk = 1'b0;
    @(negedge clk);
  endtask

  // One frame from the vsync edge; short_vc shortens one line by a pixel, stop_* aborts early.
  task automatic drive_frame(input int lines, input int short_vc, input int mode,
                             input bit lock_exp, input int stop_vc, input int stop_hc);
    bit          push_en;
    int          len, x, y;
    logic [23:0] rgb;
    exp_t        e;
    push_en = lock_exp;
    for (int vc = 0; vc < lines; vc++) begin
      len = (vc == short_vc) ? HT - 1 : HT;
      for (int hc = 0; hc < len; hc++) begin
        x   = hc - XF;
        y   = vc - YF;
        rgb = 24'h000000;
        if (x >= 0 && x < HV && y >= 0 && y < VV) begin
          rgb = pix_colour(x, y, mode);
          if (push_en) begin
            e.x   = 10'(x);
            e.y   = 10'(y);
            e.rgb = rgb;
            exp_q.push_back(e);
          end
        end
        strobe(hc < HS, vc < VS, rgb);
        if (vc == stop_vc && hc == stop_hc) return;
      end
      if (vc == short_vc) push_en = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_stats();
    pv_cnt = 0; xmin = 1023; xmax = 0; ymin = 1023; ymax = 0;
    seen_origin = 1'b0; seen_corner = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL rst_pixel_valid: got %b required 0", pixel_valid); end
    n_cmp++; if (pixel_x !== 10'd0) begin n_bad++; $display("FAIL rst_pixel_x: got %0d required 0", pixel_x); end
    n_cmp++; if (pixel_y !== 10'd0) begin n_bad++; $display("FAIL rst_pixel_y: got %0d required 0", pixel_y); end
    n_cmp++; if (pixel_rgb !== 24'd0) begin n_bad++; $display("FAIL rst_pixel_rgb: got %h required 0", pixel_rgb); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL rst_frame_start: got %b required 0", frame_start); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rst_locked: got %b required 0", locked); end
    n_cmp++; if (timing_err !== 1'b0) begin n_bad++; $display("FAIL rst_timing_err: got %b required 0", timing_err); end
    n_cmp++; if (frame_crc !== 16'd0) begin n_bad++; $display("FAIL rst_frame_crc: got %h required 0", frame_crc); end
    n_cmp++; if (frame_crc_valid !== 1'b0) begin n_bad++; $display("FAIL rst_frame_crc_valid: got %b required 0", frame_crc_valid); end
    reset = 1'b0;
  endtask

  task automatic test_lock_and_pixels();
    fs_cnt = 0; te_cnt = 0;
    drive_frame(VT, -1, 0, 1'b0, -1, -1);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_after_f1: got %b required 0", locked); end
    drive_frame(VT, -1, 0, 1'b1, -1, -1);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_after_f2: got %b required 1", locked); end
    clear_stats();
    drive_frame(VT, -1, 0, 1'b1, -1, -1);
    n_cmp++; if (pv_cnt != HV * VV) begin n_bad++; $display("FAIL f3_pixel_count: got %0d required %0d", pv_cnt, HV * VV); end
    n_cmp++; if (xmin != 0 || xmax != HV - 1) begin n_bad++; $display("FAIL f3_x_range: got %0d..%0d required 0..%0d", xmin, xmax, HV - 1); end
    n_cmp++; if (ymin != 0 || ymax != VV - 1) begin n_bad++; $display("FAIL f3_y_range: got %0d..%0d required 0..%0d", ymin, ymax, VV - 1); end
    n_cmp++; if (!seen_origin || !seen_corner) begin n_bad++; $display("FAIL f3_corners: got origin=%b corner=%b required 1 1", seen_origin, seen_corner); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL f3_missing_pixels: got %0d pending required 0", exp_q.size()); end
    n_cmp++; if (fs_cnt != 3) begin n_bad++; $display("FAIL frame_start_count: got %0d required 3", fs_cnt); end
    n_cmp++; if (te_cnt != 0) begin n_bad++; $display("FAIL clean_timing_err: got %0d required 0", te_cnt); end
  endtask

  task automatic test_short_line();
    te_cnt = 0;
    drive_frame(VT, YF + 2, 0, 1'b1, -1, -1);
    n_cmp++; if (te_cnt != 1) begin n_bad++; $display("FAIL short_line_err: got %0d pulses required 1", te_cnt); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL short_line_unlock: got %b required 0", locked); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL short_line_pending: got %0d required 0", exp_q.size()); end
    drive_frame(VT, -1, 0, 1'b0, -1, -1);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL relock_early: got %b required 0", locked); end
    drive_frame(VT, -1, 0, 1'b1, -1, -1);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL relock: got %b required 1", locked); end
    n_cmp++; if (te_cnt != 1) begin n_bad++; $display("FAIL relock_err_count: got %0d required 1", te_cnt); end
  endtask

  task automatic test_short_frame();
    do_reset();
    te_cnt = 0;
    drive_frame(VT - 1, -1, 0, 1'b0, -1, -1);
    drive_frame(VT, -1, 0, 1'b0, -1, -1);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL short_frame_nolock: got %b required 0", locked); end
    drive_frame(VT, -1, 0, 1'b1, -1, -1);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL short_frame_then_lock: got %b required 1", locked); end
    n_cmp++; if (te_cnt != 0) begin n_bad++; $display("FAIL acquire_timing_err: got %0d required 0", te_cnt); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL short_frame_pending: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_reset_midframe();
    drive_frame(VT, -1, 0, 1'b1, YF + VV / 2, XF + HV / 2);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL pre_reset_locked: got %b required 1", locked); end
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL midrst_locked: got %b required 0", locked); end
    n_cmp++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0) begin n_bad++; $display("FAIL midrst_xy: got %0d,%0d required 0,0", pixel_x, pixel_y); end
    n_cmp++; if (pixel_rgb !== 24'd0) begin n_bad++; $display("FAIL midrst_rgb: got %h required 0", pixel_rgb); end
    n_cmp++; if ({pixel_valid, frame_start, timing_err} !== 3'b000) begin n_bad++; $display("FAIL midrst_pulses: got %b required 000", {pixel_valid, frame_start, timing_err}); end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    fs_cnt = 0;
    drive_frame(VT, -1, 0, 1'b0, -1, -1);
    n_cmp++; if (locked !== 1'b0 || fs_cnt != 1) begin n_bad++; $display("FAIL after_rst_acquire: got locked=%b fs=%0d required 0 1", locked, fs_cnt); end
    drive_frame(VT, -1, 0, 1'b1, -1, -1);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL after_rst_lock: got %b required 1", locked); end
  endtask

`ifdef VGA_RX_CRC_EN
  function automatic logic [15:0] crc_model(input int mode);
    logic [15:0] c;
    logic [23:0] p;
    logic [7:0]  b;
    c = 16'hFFFF;
    for (int y = 0; y < VV; y++) begin
      for (int x = 0; x < HV; x++) begin
        p = pix_colour(x, y, mode);
        for (int k = 2; k >= 0; k--) begin
          b = p[k*8 +: 8];
          c = c ^ {b, 8'h00};
          for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
      end
    end
    return c;
  endfunction

  task automatic test_crc();
    logic [15:0] zero_crc, flip_crc;
    zero_crc = crc_model(1);
    flip_crc = crc_model(2);
    do_reset();
    crc_q.delete();
    drive_frame(VT, -1, 1, 1'b0, -1, -1);
    drive_frame(VT, -1, 1, 1'b1, -1, -1);
    drive_frame(VT, -1, 1, 1'b1, -1, -1);
    drive_frame(VT, -1, 2, 1'b1, -1, -1);
    drive_frame(VT, -1, 1, 1'b1, -1, -1);
    n_cmp++;
    if (crc_q.size() != 3) begin
      n_bad++; $display("FAIL crc_reports: got %0d required 3", crc_q.size());
    end else begin
      n_cmp++; if (crc_q[0] !== zero_crc) begin n_bad++; $display("FAIL crc_zero_1: got %h required %h", crc_q[0], zero_crc); end
      n_cmp++; if (crc_q[1] !== zero_crc) begin n_bad++; $display("FAIL crc_zero_2: got %h required %h", crc_q[1], zero_crc); end
      n_cmp++; if (crc_q[2] !== flip_crc) begin n_bad++; $display("FAIL crc_flip: got %h required %h", crc_q[2], flip_crc); end
      n_cmp++; if (crc_q[2] === crc_q[1]) begin n_bad++; $display("FAIL crc_flip_differs: got %h required a value other than %h", crc_q[2], crc_q[1]); end
    end
  endtask
`else
  task automatic test_crc();
    n_cmp++; if (crc_q.size() != 0) begin n_bad++; $display("FAIL crc_disabled_valid: got %0d reports required 0", crc_q.size()); end
    n_cmp++; if (frame_crc !== 16'd0) begin n_bad++; $display("FAIL crc_disabled_value: got %h required 0", frame_crc); end
  endtask
`endif

  initial begin
    test_reset();
    test_lock_and_pixels();
    test_short_line();
    test_short_frame();
    test_reset_midframe();
    test_crc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_rx_decoder.md
# vga_rx_decoder

Sink-side VGA decoder: samples the `hor_sync`/`ver_sync`/`red`/`green`/`blue` stream that the game's VGA controller drives, recovers pixel coordinates, checks 640x480 timing and locks onto it. It receives the same pixel strobe that the top level divides from `clk`. It is the receiving end of the video interface and serves as an on-chip monitor and a checker in the frame-capture bench. Every output is registered in the `clk` domain.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT` / `H_SYNC` / `H_BACK`, 16 / 96 / 48, horizontal porch and sync widths in pixels
- `V_VISIBLE`, 480, visible lines per frame
- `V_FRONT` / `V_SYNC` / `V_BACK`, 10 / 2 / 33, vertical porch and sync widths in lines
- `SYNC_ACTIVE_LOW`, 1, 1 means a sync is active when the pin is 0
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high
- `vga_clk` in 1: pixel strobe, 1-cycle pulse in the `clk` domain; samples are taken only when it is high
- `hor_sync`, `ver_sync` in 1: sync inputs
- `red`, `green`, `blue` in 8 each: pixel colour
- `pixel_valid` out 1: a visible pixel was sampled while LOCKED
- `pixel_x`, `pixel_y` out 10 each: coordinates of the sampled pixel
- `pixel_rgb` out 24: {red, green, blue} of the sampled pixel
- `frame_start` out 1: pulse on the vsync active edge
- `locked` out 1: high while the FSM is in LOCKED
- `timing_err` out 1: pulse on the first timing violation detected in LOCKED
- `frame_crc` out 16, `frame_crc_valid` out 1: present only with `VGA_RX_CRC_EN`

## Operation
- All logic below advances only on cycles where `vga_clk`=1 (a "strobe").
- Sync inputs pass through two flops before use. Edge detection compares the active level against the previous strobe's value.
- Horizontal counter `h_pos` (10 bit):
  - An hsync active edge sets it to 0.
  - Otherwise it increments by 1 and saturates at 1023.
  - At each hsync edge, `h_pos`≠H_TOTAL−1 (799) flags an h error.
- Vertical counter `v_pos` (10 bit):
  - A vsync active edge sets it to 0; this takes priority over an hsync edge on the same strobe.
  - Otherwise it increments by 1 on each hsync edge and saturates at 1023.
  - At each vsync edge, `v_pos`≠V_TOTAL−1 (524) flags a v error.
- Visible window:
  - `h_pos` in [144, 783] and `v_pos` in [35, 514].
  - `pixel_x` = `h_pos`−144 and `pixel_y` = `v_pos`−35, both unsigned 10 bit.
- Lock FSM, states UNLOCKED, ACQUIRE, LOCKED:
  - UNLOCKED → ACQUIRE on a vsync edge.
  - In ACQUIRE, a vsync edge with no h or v error during the frame just ended moves to LOCKED. If the frame had an error, the state stays in ACQUIRE and the error record clears.
  - LOCKED → UNLOCKED on any h or v error, with `timing_err` pulsed for 1 cycle.
- `pixel_valid` is asserted only in LOCKED and inside the visible window.
- An error that occurs in UNLOCKED or ACQUIRE never pulses `timing_err`.
- `frame_start` pulses on every vsync edge, in every state.

## Timing
- Reset values:
  - All outputs 0 and the FSM in UNLOCKED.
  - `h_pos` and `v_pos` at 1023 (saturated), so the first edge is never flagged as an error.
- Latency: the pixel outputs update 1 `clk` after the strobe that sampled the pixel.
  - With the synchroniser, sync decisions lag the pin by 2 strobes. RGB is delayed by the same 2 strobes so colour stays aligned with its coordinates.
- Lock is reached at the earliest on the second vsync edge after reset, i.e. about 1 frame after the first.
- When `vga_clk` is absent, every counter and output holds; no timeout is applied.
- A reset asserted mid-frame clears immediately and asynchronously; operation restarts from UNLOCKED.

## Configuration
- `VGA_RX_CRC_EN` defined:
  - CRC-16-CCITT (polynomial 0x1021, init 0xFFFF) runs over `pixel_rgb` of every valid pixel, MSB byte first, 3 bytes per pixel.
  - On the vsync edge, `frame_crc` latches the result, `frame_crc_valid` pulses for 1 `clk`, and the CRC re-initialises.
  - A CRC is only reported for a frame that was LOCKED for its whole duration.
- `VGA_RX_CRC_EN` undefined: `frame_crc` and `frame_crc_valid` are tied to 0 and no CRC logic is built.

## Structure
- Package `vga_rx_pkg` holds:
  - the FSM state enum;
  - derived constants H_TOTAL, V_TOTAL, H_START=H_SYNC+H_BACK and V_START=V_SYNC+V_BACK;
  - the CRC polynomial and init value.
- One sub-module, `vga_rx_crc16`, does the byte-serial CRC (3 bytes per pixel, processed within 1 `clk`). It is instantiated only under the macro.

## Test plan
- Drive 3 clean 800x525 frames, strobe every 2 `clk` → `locked`=1 after the 2nd vsync edge; frame 3 gives 307200 `pixel_valid` pulses with `pixel_x` 0..639 and `pixel_y` 0..479.
- Visible pixel colour = {x[7:0], y[7:0], 8'hA5} → each `pixel_rgb` matches its own `pixel_x`/`pixel_y`, including at (0,0) and (639,479).
- While LOCKED, shorten one line to 799 pixels → a single `timing_err` pulse, `locked` drops, and `pixel_valid` stays 0 until re-lock 2 vsync edges later.
- Frame with 524 lines during ACQUIRE → no `timing_err`, no lock; the next clean frame locks.
- Assert `reset` at pixel (320,240) → all outputs 0 within the same cycle; the next vsync edge gives ACQUIRE.
- With `VGA_RX_CRC_EN`, a constant all-zero frame gives the same `frame_crc` on two successive frames, and that value matches the bench model. Flipping one pixel changes it.
